fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register and squash tracker
// Optional feature macro: FETCH_REDIRECT_COUNT_EN adds a saturating redirect counter output.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        instr_flush,
  input  logic        instr_flush_2,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  output logic        del_instr,
`ifdef FETCH_REDIRECT_COUNT_EN
  output logic        del_instr_2,
  output logic [15:0] redirect_count
`else
  output logic        del_instr_2
`endif
);

  localparam logic [15:0] BUBBLE = 16'hF000;

  typedef enum logic [1:0] {IDLE, KILL1, KILL2} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        del_q, del_d;
  logic        del2_q, del2_d;

  logic advance;
  logic flush_ok;

  assign advance  = !stall && !redirect_en;
  // A flush only counts when it comes from a live, unsquashed instruction and no squash is in flight.
  assign flush_ok = advance && valid_q && !del_q && !del2_q && (state_q == IDLE);

  // Squash tracker state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Squash tracker next state: redirect cancels, advances step the sequence down
  always_comb begin
    state_d = state_q;
    if (redirect_en) begin
      state_d = IDLE;
    end else if (advance) begin
      case (state_q)
        IDLE: begin
          if (flush_ok && instr_flush_2)    state_d = KILL2;
          else if (flush_ok && instr_flush) state_d = KILL1;
          else                              state_d = IDLE;
        end
        KILL2:   state_d = KILL1;
        KILL1:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Squash flags for the instruction being captured follow the state being entered
  always_comb begin
    del_d  = del_q;
    del2_d = del2_q;
    if (redirect_en) begin
      del_d  = 1'b1;
      del2_d = 1'b0;
    end else if (advance) begin
      del_d  = (state_d == KILL1);
      del2_d = (state_d == KILL2);
    end
  end

  // PC and IF/ID next values: redirect loads a bubble, stall holds, advance fetches
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    if (redirect_en) begin
      pc_d    = redirect_pc;
      instr_d = BUBBLE;
      ipc_d   = pc_q;
      valid_d = 1'b0;
    end else if (advance) begin
      pc_d    = pc_q + 16'd1;
      instr_d = imem_data;
      ipc_d   = pc_q;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= 16'h0000;
      instr_q <= BUBBLE;
      ipc_q   <= 16'h0000;
      valid_q <= 1'b0;
      del_q   <= 1'b1;
      del2_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      del_q   <= del_d;
      del2_q  <= del2_d;
    end
  end

`ifdef FETCH_REDIRECT_COUNT_EN
  logic [15:0] rcnt_q;

  // Saturating count of redirect cycles
  always_ff @(posedge clk) begin
    if (reset)                              rcnt_q <= 16'h0000;
    else if (redirect_en && rcnt_q != 16'hFFFF) rcnt_q <= rcnt_q + 16'd1;
  end

  assign redirect_count = rcnt_q;
`endif

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign del_instr   = del_q;
  assign del_instr_2 = del2_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage (directed table plus random vs. queue model)
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_en, instr_flush, instr_flush_2;
  logic [15:0] redirect_pc, imem_addr, imem_data, instruction, instr_pc;
  logic        instr_valid, del_instr, del_instr_2;
  logic [15:0] salt = 16'h0000;
`ifdef FETCH_REDIRECT_COUNT_EN
  logic [15:0] redirect_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_data = (16'h1000 + imem_addr) ^ salt;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .instr_flush(instr_flush), .instr_flush_2(instr_flush_2),
    .imem_addr(imem_addr), .imem_data(imem_data), .instruction(instruction),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .del_instr(del_instr),
`ifdef FETCH_REDIRECT_COUNT_EN
    .del_instr_2(del_instr_2), .redirect_count(redirect_count)
`else
    .del_instr_2(del_instr_2)
`endif
  );

  typedef struct {
    logic        rst, stl, rd;
    logic [15:0] rpc;
    logic        f1, f2;
    logic [15:0] e_addr, e_instr, e_ipc;
    logic        e_valid, e_del, e_del2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [15:0] rpc,
                       input logic f1, input logic f2);
    reset = r; stall = s; redirect_en = rd; redirect_pc = rpc;
    instr_flush = f1; instr_flush_2 = f2;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input logic [15:0] a, input logic [15:0] ins, input logic [15:0] ipc,
                           input logic v, input logic d, input logic d2);
    chk("imem_addr", imem_addr, a);
    chk("instruction", instruction, ins);
    if (v) chk("instr_pc", instr_pc, ipc);
    chk("instr_valid", {15'd0, instr_valid}, {15'd0, v});
    chk("del_instr", {15'd0, del_instr}, {15'd0, d});
    chk("del_instr_2", {15'd0, del_instr_2}, {15'd0, d2});
  endtask

  // Reference model: squash marks for upcoming captures kept in a queue of {del, del2}
  logic [15:0] m_pc, m_instr, m_ipc, m_cnt;
  logic        m_valid, m_del, m_del2;
  logic [1:0]  marks[$];

  task automatic model_step(input logic r, input logic s, input logic rd, input logic [15:0] rpc,
                            input logic f1, input logic f2);
    logic [1:0] cur;
    if (r) begin
      m_pc = 0; m_instr = 16'hF000; m_ipc = 0; m_valid = 0; m_del = 1; m_del2 = 0;
      m_cnt = 0; marks.delete();
    end else if (rd) begin
      m_pc = rpc; m_instr = 16'hF000; m_valid = 0; m_del = 1; m_del2 = 0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      marks.delete();
    end else if (!s) begin
      cur = 2'b00;
      if (marks.size() == 0 && m_valid && !m_del && !m_del2 && (f1 || f2)) begin
        if (f2) begin cur = 2'b01; marks.push_back(2'b10); end
        else    cur = 2'b10;
      end else if (marks.size() != 0) begin
        cur = marks.pop_front();
      end
      m_instr = (16'h1000 + m_pc) ^ salt;
      m_ipc = m_pc; m_valid = 1; m_del = cur[1]; m_del2 = cur[0];
      m_pc = m_pc + 1;
    end
  endtask

  initial begin
    //                rst stl rd rpc       f1 f2  addr      instr     ipc       v  d  d2
    vecs.push_back('{1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'hF000, 16'h0000, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0001, 16'h1000, 16'h0000, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0002, 16'h1001, 16'h0001, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0003, 16'h1002, 16'h0002, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0004, 16'h1003, 16'h0003, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0005, 16'h1004, 16'h0004, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0000, 0, 0, 16'h0005, 16'h1004, 16'h0004, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0000, 0, 0, 16'h0005, 16'h1004, 16'h0004, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0006, 16'h1005, 16'h0005, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 1, 0, 16'h0007, 16'h1006, 16'h0006, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0008, 16'h1007, 16'h0007, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 1, 16'h0009, 16'h1008, 16'h0008, 1, 0, 1});
    vecs.push_back('{0, 0, 0, 16'h0000, 1, 0, 16'h000A, 16'h1009, 16'h0009, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 1, 0, 16'h000B, 16'h100A, 16'h000A, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0000, 1, 0, 16'h000B, 16'h100A, 16'h000A, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h000C, 16'h100B, 16'h000B, 1, 0, 0});
    vecs.push_back('{0, 1, 1, 16'h0040, 1, 0, 16'h0040, 16'hF000, 16'h0000, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0041, 16'h1040, 16'h0040, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 1, 16'h0042, 16'h1041, 16'h0041, 1, 0, 1});
    vecs.push_back('{0, 0, 1, 16'h0080, 0, 0, 16'h0080, 16'hF000, 16'h0000, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0081, 16'h1080, 16'h0080, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 1, 16'h0082, 16'h1081, 16'h0081, 1, 0, 1});
    vecs.push_back('{1, 1, 1, 16'h0077, 0, 0, 16'h0000, 16'hF000, 16'h0000, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0001, 16'h1000, 16'h0000, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 16'hFFFF, 0, 0, 16'hFFFF, 16'hF000, 16'h0000, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0FFF, 16'hFFFF, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 0, 0, 16'h0001, 16'h1000, 16'h0000, 1, 0, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].rd, vecs[i].rpc, vecs[i].f1, vecs[i].f2);
      check_all(vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_ipc,
                vecs[i].e_valid, vecs[i].e_del, vecs[i].e_del2);
    end

    salt = 16'($urandom);
    for (int n = 0; n < 600; n++) begin
      logic r, s, rd, f1, f2;
      logic [15:0] rpc;
      r   = (n == 0) || ($urandom_range(0, 63) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      f1  = ($urandom_range(0, 3) == 0);
      f2  = ($urandom_range(0, 5) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      drive(r, s, rd, rpc, f1, f2);
      model_step(r, s, rd, rpc, f1, f2);
      check_all(m_pc, m_instr, m_ipc, m_valid, m_del, m_del2);
`ifdef FETCH_REDIRECT_COUNT_EN
      chk("redirect_count", redirect_count, m_cnt);
`endif
    end

`ifdef FETCH_REDIRECT_COUNT_EN
    drive(1, 0, 0, 16'h0000, 0, 0);
    chk("redirect_count_reset", redirect_count, 16'd0);
    for (int k = 0; k < 3; k++) drive(0, k[0], 1, 16'h0010, 0, 0);
    drive(0, 0, 0, 16'h0000, 0, 0);
    chk("redirect_count_three", redirect_count, 16'd3);
    drive(1, 0, 1, 16'h0000, 0, 0);
    chk("redirect_count_cleared", redirect_count, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
